// File: rtl/freq_gate_ctrl_pkg.sv
// Shared types and defaults for the frequency measurement path (gate control and freq_cal).
package freq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   localparam int GATE_CYCLES_DEF = 250;
   localparam int DEAD_CYCLES_DEF = 4;
   localparam int WIN_W           = 8;

   function automatic logic [WIN_W-1:0] next_win(input logic [WIN_W-1:0] cnt);
      return cnt + {{(WIN_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/status bundle between the measurement controller and freq_gate_ctrl.
interface freq_gate_ctrl_if;
   import freq_pkg::*;

   logic             start;
   logic             stop;
   logic             cont;
   logic             sig_in;
   logic             en;
   logic             sig_pulse;
   logic             busy;
   logic             done;
   logic [WIN_W-1:0] win_cnt;

   modport master (
      output start, stop, cont, sig_in,
      input  en, sig_pulse, busy, done, win_cnt
   );

   modport slave (
      input  start, stop, cont, sig_in,
      output en, sig_pulse, busy, done, win_cnt
   );

endinterface

// File: rtl/freq_gate_ctrl_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Synchroniser chain plus one delay stage for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= async_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate window generator for freq_cal: one-shot/continuous windows with dead time,
// synchronised edge pulses inside the window, and a completed-window counter.
module freq_gate_ctrl
   import freq_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   freq_gate_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_en;
   logic             r_busy;
   logic             r_done;
   logic             r_sig_pulse;
   logic [WIN_W-1:0] r_win_cnt;
   logic             w_rise;

   sync_edge_det u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (bus.sig_in),
      .rise     (w_rise)
   );

   // Window FSM, gate/dead counter and all registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_en        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sig_pulse <= 1'b0;
         r_win_cnt   <= '0;
      end else begin
         r_done      <= 1'b0;
         r_sig_pulse <= w_rise & r_en;
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  r_state <= ST_GATE;
                  r_cnt   <= '0;
                  r_en    <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_GATE: begin
               // stop outranks window completion, so an abort on the last cycle never counts
               if (bus.stop) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == GATE_LAST) begin
                  r_state   <= ST_DEAD;
                  r_cnt     <= '0;
                  r_en      <= 1'b0;
                  r_done    <= 1'b1;
                  r_win_cnt <= next_win(r_win_cnt);
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_DEAD: begin
               if (bus.stop) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == DEAD_LAST) begin
                  r_cnt <= '0;
                  if (bus.cont) begin
                     r_state <= ST_GATE;
                     r_en    <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.en        = r_en;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sig_pulse = r_sig_pulse;
   assign bus.win_cnt   = r_win_cnt;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl: a window-offset reference model queues the
// expected outputs per clock; an independent monitor compares them after each edge.
module tb_freq_gate_ctrl;
   import freq_pkg::*;

   localparam int G = 8;
   localparam int D = 2;

   typedef struct packed {
      logic       en;
      logic       sig_pulse;
      logic       busy;
      logic       done;
      logic [7:0] win;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   freq_gate_ctrl_if bus ();

   freq_gate_ctrl #(
      .GATE_CYCLES (G),
      .DEAD_CYCLES (D),
      .CNT_W       (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: position inside the current G+D window, plus sig_in history
   bit m_active = 1'b0;
   int m_off    = 0;
   int m_win    = 0;
   bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
   bit en_prev  = 1'b0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
      end
   endtask

   task automatic step(input bit rst, input bit st, input bit sp, input bit ct, input bit sg);
      exp_t e;
      bit   pulse;
      @(negedge clk);
      reset      = rst;
      bus.start  = st;
      bus.stop   = sp;
      bus.cont   = ct;
      bus.sig_in = sg;
      e = '0;
      if (!rst) begin
         m_active = 1'b0; m_off = 0; m_win = 0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; en_prev = 1'b0;
      end else begin
         pulse = h2 & ~h3 & en_prev;
         if (!m_active) begin
            if (st && !sp) begin
               m_active = 1'b1;
               m_off    = 0;
            end
         end else if (sp) begin
            m_active = 1'b0;
         end else if (m_off == G + D - 1) begin
            if (ct) m_off = 0;
            else    m_active = 1'b0;
         end else begin
            m_off++;
            if (m_off == G) m_win = (m_win + 1) % 256;
         end
         e.en        = m_active && (m_off < G);
         e.busy      = m_active;
         e.done      = m_active && (m_off == G);
         e.sig_pulse = pulse;
         e.win       = 8'(m_win);
         h3 = h2; h2 = h1; h1 = sg;
         en_prev = e.en;
      end
      exp_q.push_back(e);
   endtask

   // monitor: one expected record per clock edge once stimulus has started
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("en",        int'(bus.en),        int'(e.en));
         chk("busy",      int'(bus.busy),      int'(e.busy));
         chk("done",      int'(bus.done),      int'(e.done));
         chk("sig_pulse", int'(bus.sig_pulse), int'(e.sig_pulse));
         chk("win_cnt",   int'(bus.win_cnt),   int'(e.win));
      end
   end

   initial begin
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.cont   = 1'b0;
      bus.sig_in = 1'b0;

      // reset held with start toggling
      for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // one-shot window
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // continuous: three windows, then drop cont
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (25) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // period-4 square wave aligned to start
      for (int i = 0; i < 24; i++) step(1'b1, 1'(i == 0), 1'b0, 1'b0, 1'((i % 4) < 2));

      // abort on gate cycle 5 and on the last gate cycle
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // start and stop together in idle
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset mid-gate, then 256 one-shot windows with start spam while busy
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 256; w++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         for (int j = 0; j < 11; j++)
            step(1'b1, 1'((j < 9) && ($urandom_range(0, 2) == 0)), 1'b0, 1'b0,
                 1'($urandom_range(0, 1)));
      end

      // random traffic
      for (int i = 0; i < 1500; i++)
         step(1'b1, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
